mem_port_arbiter: RTL and testbench

//  Shares the single memory port (Mem_Addr/Mem_Write/Mem_Data) between three requesters:
//  VGA row fetch (read-only, real-time), the CPU, and a serial DMA engine.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for a single memory port: VGA row fetch (priority, burst-limited),
// CPU and DMA (round-robin). One transaction in flight at a time, one Ack per transaction.
module mem_port_arbiter #(
    parameter int READ_LATENCY  = 1,
    parameter int VGA_BURST_MAX = 4
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VGA_Req,
    input  logic [15:0] VGA_Addr,
    output logic        VGA_Ack,
    input  logic        CPU_Req,
    input  logic [15:0] CPU_Addr,
    input  logic        CPU_Write,
    input  logic [15:0] CPU_WData,
    output logic        CPU_Ack,
    input  logic        DMA_Req,
    input  logic [15:0] DMA_Addr,
    input  logic        DMA_Write,
    input  logic [15:0] DMA_WData,
    output logic        DMA_Ack,
    output logic [15:0] RData,
    output logic [15:0] Mem_Addr,
    output logic        Mem_Write,
    output logic [15:0] Mem_WData,
    input  logic [15:0] Mem_Data,
    output logic        Busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU, OWN_DMA} owner_t;

    localparam logic [3:0] BURST_MAX = 4'(VGA_BURST_MAX);
    localparam logic [2:0] LAT_LAST  = 3'(READ_LATENCY - 1);

    state_t     state;
    owner_t     owner;
    owner_t     win;
    logic       is_write;
    logic [2:0] cnt;
    logic [3:0] vga_run;
    logic       rr_last_dma;
    logic       vga_blocked;

    // VGA yields only once its burst budget is spent and someone else is waiting.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        win         = OWN_NONE;
        vga_blocked = (vga_run == BURST_MAX) && (CPU_Req || DMA_Req);
        if (VGA_Req && !vga_blocked)
            win = OWN_VGA;
        else if (CPU_Req && DMA_Req)
            win = rr_last_dma ? OWN_CPU : OWN_DMA;
        else if (CPU_Req)
            win = OWN_CPU;
        else if (DMA_Req)
            win = OWN_DMA;
    end

    // NOTE: all sequential state uses non-blocking assignments; the async reset is the
    // only way an in-flight transaction is abandoned, and it also drops Mem_Write at once.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            is_write    <= 1'b0;
            cnt         <= '0;
            vga_run     <= '0;
            rr_last_dma <= 1'b1;
            VGA_Ack     <= 1'b0;
            CPU_Ack     <= 1'b0;
            DMA_Ack     <= 1'b0;
            RData       <= '0;
            Mem_Addr    <= '0;
            Mem_Write   <= 1'b0;
            Mem_WData   <= '0;
            Busy        <= 1'b0;
        end else begin
            VGA_Ack   <= 1'b0;
            CPU_Ack   <= 1'b0;
            DMA_Ack   <= 1'b0;
            Mem_Write <= 1'b0;
            unique case (state)
                IDLE: begin
                    Mem_Addr <= '0;
                    if (!VGA_Req)
                        vga_run <= '0;
                    if (win != OWN_NONE) begin
                        owner <= win;
                        cnt   <= '0;
                        state <= ACCESS;
                        Busy  <= 1'b1;
                    end
                    unique case (win)
                        OWN_VGA: begin
                            Mem_Addr  <= VGA_Addr;
                            Mem_WData <= '0;
                            is_write  <= 1'b0;
                            if (vga_run != BURST_MAX)
                                vga_run <= vga_run + 4'd1;
                        end
                        OWN_CPU: begin
                            Mem_Addr    <= CPU_Addr;
                            Mem_WData   <= CPU_WData;
                            Mem_Write   <= CPU_Write;
                            is_write    <= CPU_Write;
                            vga_run     <= '0;
                            rr_last_dma <= 1'b0;
                        end
                        OWN_DMA: begin
                            Mem_Addr    <= DMA_Addr;
                            Mem_WData   <= DMA_WData;
                            Mem_Write   <= DMA_Write;
                            is_write    <= DMA_Write;
                            vga_run     <= '0;
                            rr_last_dma <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                ACCESS: begin
                    if (is_write || cnt == LAT_LAST) begin
                        state <= ACK;
                        if (!is_write)
                            RData <= Mem_Data;
                        unique case (owner)
                            OWN_VGA: VGA_Ack <= 1'b1;
                            OWN_CPU: CPU_Ack <= 1'b1;
                            OWN_DMA: DMA_Ack <= 1'b1;
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    Busy     <= 1'b0;
                    Mem_Addr <= '0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LATENCY=1 for arbitration and
// handshakes, a second at READ_LATENCY=3 for the long-latency read path.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        vga_req, cpu_req, dma_req;
    logic [15:0] vga_addr, cpu_addr, dma_addr, cpu_wdata, dma_wdata;
    logic        cpu_write, dma_write;
    logic        vga_ack, cpu_ack, dma_ack, mem_write, busy;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_data;

    logic        b_vga_req, b_cpu_req, b_dma_req;
    logic [15:0] b_vga_addr, b_cpu_addr, b_dma_addr, b_cpu_wdata, b_dma_wdata;
    logic        b_cpu_write, b_dma_write;
    logic        b_vga_ack, b_cpu_ack, b_dma_ack, b_mem_write, b_busy;
    logic [15:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_data;
    logic [15:0] b_addr_d1, b_addr_d2;

    int errors = 0;
    int checks = 0;
    int n_acks;
    int multi;
    int seq [16];

    function automatic logic [15:0] lookup(input logic [15:0] a);
        return (a == 16'h0040) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    mem_port_arbiter #(.READ_LATENCY(1), .VGA_BURST_MAX(4)) u_dut (
        .Clock(clk), .Reset(rst),
        .VGA_Req(vga_req), .VGA_Addr(vga_addr), .VGA_Ack(vga_ack),
        .CPU_Req(cpu_req), .CPU_Addr(cpu_addr), .CPU_Write(cpu_write),
        .CPU_WData(cpu_wdata), .CPU_Ack(cpu_ack),
        .DMA_Req(dma_req), .DMA_Addr(dma_addr), .DMA_Write(dma_write),
        .DMA_WData(dma_wdata), .DMA_Ack(dma_ack),
        .RData(rdata), .Mem_Addr(mem_addr), .Mem_Write(mem_write),
        .Mem_WData(mem_wdata), .Mem_Data(mem_data), .Busy(busy)
    );

    mem_port_arbiter #(.READ_LATENCY(3), .VGA_BURST_MAX(4)) u_dut3 (
        .Clock(clk), .Reset(rst),
        .VGA_Req(b_vga_req), .VGA_Addr(b_vga_addr), .VGA_Ack(b_vga_ack),
        .CPU_Req(b_cpu_req), .CPU_Addr(b_cpu_addr), .CPU_Write(b_cpu_write),
        .CPU_WData(b_cpu_wdata), .CPU_Ack(b_cpu_ack),
        .DMA_Req(b_dma_req), .DMA_Addr(b_dma_addr), .DMA_Write(b_dma_write),
        .DMA_WData(b_dma_wdata), .DMA_Ack(b_dma_ack),
        .RData(b_rdata), .Mem_Addr(b_mem_addr), .Mem_Write(b_mem_write),
        .Mem_WData(b_mem_wdata), .Mem_Data(b_mem_data), .Busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: zero-latency for the first instance, two address delays for the second.
    always_comb mem_data = lookup(mem_addr);
    always @(posedge clk) begin
        b_addr_d1 <= b_mem_addr;
        b_addr_d2 <= b_addr_d1;
    end
    always_comb b_mem_data = lookup(b_addr_d2);

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic record_acks();
        if ($countones({vga_ack, cpu_ack, dma_ack}) > 1) multi++;
        if (n_acks < 16) begin
            if (vga_ack) seq[n_acks++] = 1;
            else if (cpu_ack) seq[n_acks++] = 2;
            else if (dma_ack) seq[n_acks++] = 3;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp4 [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};

        rst = 1'b1;
        {vga_req, cpu_req, dma_req, cpu_write, dma_write} = '0;
        {vga_addr, cpu_addr, dma_addr, cpu_wdata, dma_wdata} = '0;
        {b_vga_req, b_cpu_req, b_dma_req, b_cpu_write, b_dma_write} = '0;
        {b_vga_addr, b_cpu_addr, b_dma_addr, b_cpu_wdata, b_dma_wdata} = '0;
        repeat (2) tick();
        check("rst_busy", 16'(busy), 16'd0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_write", 16'(mem_write), 16'd0);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_acks", 16'({vga_ack, cpu_ack, dma_ack}), 16'd0);
        rst = 1'b0;

        // CPU read of 0x0040; Req dropped mid-transaction, Ack still expected
        cpu_req = 1'b1; cpu_addr = 16'h0040; cpu_write = 1'b0;
        tick();
        check("rd_mem_addr", mem_addr, 16'h0040);
        check("rd_busy", 16'(busy), 16'd1);
        check("rd_no_early_ack", 16'(cpu_ack), 16'd0);
        cpu_req = 1'b0; cpu_addr = 16'h7777;
        tick();
        check("rd_ack", 16'(cpu_ack), 16'd1);
        check("rd_rdata", rdata, 16'hBEEF);
        tick();
        check("rd_ack_one_cycle", 16'(cpu_ack), 16'd0);
        check("rd_idle_busy", 16'(busy), 16'd0);
        check("rd_idle_addr", mem_addr, 16'h0000);

        // CPU write 0x1234 to 0x0100; late changes to WData must be ignored
        cpu_req = 1'b1; cpu_addr = 16'h0100; cpu_write = 1'b1; cpu_wdata = 16'h1234;
        tick();
        check("wr_strobe", 16'(mem_write), 16'd1);
        check("wr_addr", mem_addr, 16'h0100);
        check("wr_wdata", mem_wdata, 16'h1234);
        check("wr_no_early_ack", 16'(cpu_ack), 16'd0);
        cpu_req = 1'b0; cpu_wdata = 16'hFFFF;
        tick();
        check("wr_strobe_drop", 16'(mem_write), 16'd0);
        check("wr_ack", 16'(cpu_ack), 16'd1);
        check("wr_rdata_kept", rdata, 16'hBEEF);
        tick();
        check("wr_ack_one_cycle", 16'(cpu_ack), 16'd0);

        // CPU and DMA both held: CPU first after reset, then alternate
        pulse_reset();
        cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_write = 1'b0;
        dma_req = 1'b1; dma_addr = 16'h0020; dma_write = 1'b0;
        n_acks = 0; multi = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            record_acks();
            if (cpu_ack) check("rr_cpu_rdata", rdata, 16'hA5B5);
            if (dma_ack) check("rr_dma_rdata", rdata, 16'hA585);
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        check("rr_ack_count", 16'(n_acks), 16'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rr_order_%0d", i), 16'(seq[i]), (i % 2 == 0) ? 16'd2 : 16'd3);
        check("rr_single_ack", 16'(multi), 16'd0);
        repeat (4) tick();

        // VGA and CPU held: four VGA grants then one CPU, repeating
        pulse_reset();
        vga_req = 1'b1; vga_addr = 16'h0200;
        cpu_req = 1'b1; cpu_addr = 16'h0010; cpu_write = 1'b0;
        n_acks = 0; multi = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            record_acks();
        end
        vga_req = 1'b0; cpu_req = 1'b0;
        check("burst_ack_count", 16'(n_acks), 16'd10);
        for (int i = 0; i < 10; i++)
            check($sformatf("burst_order_%0d", i), 16'(seq[i]), 16'(exp4[i]));
        check("burst_single_ack", 16'(multi), 16'd0);
        repeat (4) tick();

        // Reset during a DMA write: strobe drops at once, no Ack, regrant after release
        dma_req = 1'b1; dma_addr = 16'h0300; dma_write = 1'b1; dma_wdata = 16'h5A5A;
        tick();
        check("dma_wr_strobe", 16'(mem_write), 16'd1);
        #3 rst = 1'b1;
        #1;
        check("dma_rst_strobe", 16'(mem_write), 16'd0);
        check("dma_rst_busy", 16'(busy), 16'd0);
        tick();
        check("dma_rst_no_ack", 16'(dma_ack), 16'd0);
        rst = 1'b0;
        tick();
        check("dma_regrant_busy", 16'(busy), 16'd1);
        check("dma_regrant_strobe", 16'(mem_write), 16'd1);
        check("dma_regrant_addr", mem_addr, 16'h0300);
        dma_req = 1'b0;
        tick();
        check("dma_regrant_ack", 16'(dma_ack), 16'd1);
        tick();

        // READ_LATENCY=3 VGA read; address changes after the grant are ignored
        b_vga_req = 1'b1; b_vga_addr = 16'h0444;
        tick();
        check("lat3_addr_c1", b_mem_addr, 16'h0444);
        b_vga_req = 1'b0; b_vga_addr = 16'h0999;
        tick();
        check("lat3_addr_c2", b_mem_addr, 16'h0444);
        check("lat3_no_ack_c2", 16'(b_vga_ack), 16'd0);
        tick();
        check("lat3_addr_c3", b_mem_addr, 16'h0444);
        check("lat3_no_ack_c3", 16'(b_vga_ack), 16'd0);
        tick();
        check("lat3_ack", 16'(b_vga_ack), 16'd1);
        check("lat3_rdata", b_rdata, 16'hA1E1);
        tick();
        check("lat3_ack_one_cycle", 16'(b_vga_ack), 16'd0);
        check("lat3_idle_busy", 16'(b_busy), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
